pattern_event_logger: RTL and testbench

- Downstream consumer of the pattern detector's found_pattern/ack handshake.
- Acknowledges each detection with a one-cycle ack pulse.
- Time-stamps each match with the byte position in the input stream and queues {sequence number, position} records in a small FIFO for a host/readout stage.
- Maintains a running match count and sticky overflow / stuck-flag error indicators.

---
 rtl/pattern_evt_pkg.sv | 25 ++
 rtl/evt_fifo.sv | 53 +++++
 rtl/pattern_event_logger.sv | 149 ++++++++++++++
 tb/tb_pattern_event_logger.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pattern_evt_pkg.sv
// Shared types and default constants for the pattern event logger.
//   evt_rec_t      : one logged match {seq, pos} at the default widths
//   logger_state_t : acknowledge FSM states
package pattern_evt_pkg;

  localparam int DEF_DEPTH       = 8;
  localparam int DEF_POS_W       = 16;
  localparam int DEF_SEQ_W       = 8;
  localparam int DEF_STUCK_LIMIT = 4;

  // Record layout: sequence number in the upper bits, stream position below.
  // The FIFO stores the same {seq, pos} packing as a flat vector so that
  // non-default widths keep the identical layout.
  typedef struct packed {
    logic [DEF_SEQ_W-1:0] seq;
    logic [DEF_POS_W-1:0] pos;
  } evt_rec_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACK      = 2'd1,
    WAIT_CLR = 2'd2
  } logger_state_t;

endpackage

// File: rtl/evt_fifo.sv
// Synchronous FIFO of packed {seq, pos} match records.
//   clk, rst      : clock, asynchronous active-high reset (pointers only)
//   push, wr_data : write request and record; ignored when full unless a
//                   pop takes effect in the same cycle
//   pop           : read request; ignored when empty
//   rd_data       : head record (zero while empty), combinational
//   full, empty   : occupancy flags
module evt_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wr_data,
  input  logic         pop,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit separates the full case from the empty case.
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [W-1:0] mem [DEPTH];
  logic         do_push;
  logic         do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push at full still lands.
  assign do_push = push && (!full || do_pop);
  // Masked while empty so stale storage never shows on the read port.
  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/pattern_event_logger.sv
// Consumes found_pattern from a pattern detector, returns a one-cycle ack,
// and logs each match as a {sequence number, stream position} record.
//   clk, reset_sync    : clock, asynchronous active-high reset
//   found_pattern, ack : detector handshake (flag held until acked)
//   rd_en, rd_valid,
//   rd_seq, rd_pos     : record readout
//   match_count        : matches since reset (wraps)
//   overflow, stuck_err: sticky error flags, cleared by clear_err
//   state_dbg          : current FSM state (logger_state_t encoding)
//
// Readout handshake: rd_valid means a record is presented on rd_seq/rd_pos;
// the record is consumed on a rising edge where rd_valid && rd_en. rd_en with
// rd_valid low has no effect. Presented data stays stable until consumed.
module pattern_event_logger
  import pattern_evt_pkg::*;
#(
  parameter int DEPTH       = DEF_DEPTH,
  parameter int POS_W       = DEF_POS_W,
  parameter int SEQ_W       = DEF_SEQ_W,
  parameter int STUCK_LIMIT = DEF_STUCK_LIMIT
) (
  input  logic             clk,
  input  logic             reset_sync,
  input  logic             found_pattern,
  output logic             ack,
  input  logic             rd_en,
  output logic             rd_valid,
  output logic [SEQ_W-1:0] rd_seq,
  output logic [POS_W-1:0] rd_pos,
  output logic [SEQ_W-1:0] match_count,
  output logic             overflow,
  output logic             stuck_err,
  input  logic             clear_err,
  output logic [1:0]       state_dbg
);

  localparam int SW    = $clog2(STUCK_LIMIT + 1);
  localparam int REC_W = SEQ_W + POS_W;

  logger_state_t    state;
  logger_state_t    state_next;
  logic [SW-1:0]    stuck_cnt;
  logic [SW-1:0]    stuck_cnt_next;
  logic             push;
  logic             stuck_hit;
  logic             drop;
  logic [POS_W-1:0] pos;
  logic [SEQ_W-1:0] count;
  logic             fifo_full;
  logic             fifo_empty;
  logic [REC_W-1:0] head;

  // FSM: state register
  always_ff @(posedge clk or posedge reset_sync) begin
    if (reset_sync) begin
      state     <= IDLE;
      stuck_cnt <= '0;
    end else begin
      state     <= state_next;
      stuck_cnt <= stuck_cnt_next;
    end
  end

  // FSM: next state. A match is accepted only in IDLE; the flag is ignored
  // during ACK. If it never drops in WAIT_CLR we give up after STUCK_LIMIT
  // cycles and the still-high flag is taken as a fresh match from IDLE.
  always_comb begin
    state_next     = state;
    stuck_cnt_next = stuck_cnt;
    push           = 1'b0;
    stuck_hit      = 1'b0;
    case (state)
      IDLE: begin
        if (found_pattern) begin
          push       = 1'b1;
          state_next = ACK;
        end
      end
      ACK: begin
        state_next     = WAIT_CLR;
        stuck_cnt_next = '0;
      end
      WAIT_CLR: begin
        if (!found_pattern) begin
          state_next = IDLE;
        end else if (stuck_cnt == SW'(STUCK_LIMIT - 1)) begin
          stuck_hit  = 1'b1;
          state_next = IDLE;
        end else begin
          stuck_cnt_next = stuck_cnt + SW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM: outputs, decoded from the registered state only
  always_comb begin
    ack       = (state == ACK);
    state_dbg = state;
  end

  // Stream position and match counter
  always_ff @(posedge clk or posedge reset_sync) begin
    if (reset_sync) begin
      pos   <= '0;
      count <= '0;
    end else begin
      pos <= pos + POS_W'(1);
      if (push) count <= count + SEQ_W'(1);
    end
  end

  // A record is lost only when full with no pop to make room.
  assign drop = push && fifo_full && !rd_en;

  // Sticky error flags; a set in the same cycle beats clear_err.
  always_ff @(posedge clk or posedge reset_sync) begin
    if (reset_sync) begin
      overflow  <= 1'b0;
      stuck_err <= 1'b0;
    end else begin
      if (drop)           overflow <= 1'b1;
      else if (clear_err) overflow <= 1'b0;
      if (stuck_hit)      stuck_err <= 1'b1;
      else if (clear_err) stuck_err <= 1'b0;
    end
  end

  evt_fifo #(
    .DEPTH (DEPTH),
    .W     (REC_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (reset_sync),
    .push    (push),
    .wr_data ({count, pos}),
    .pop     (rd_en),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign rd_valid    = !fifo_empty;
  assign rd_seq      = head[REC_W-1:POS_W];
  assign rd_pos      = head[POS_W-1:0];
  assign match_count = count;

endmodule

// File: tb/tb_pattern_event_logger.sv
module tb_pattern_event_logger;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        found = 1'b0;
  logic        rd_en = 1'b0;
  logic        clear_err = 1'b0;
  logic        ack;
  logic        rd_valid;
  logic [7:0]  rd_seq;
  logic [15:0] rd_pos;
  logic [7:0]  match_count;
  logic        overflow;
  logic        stuck_err;
  logic [1:0]  state_dbg;

  // Narrow-position instance for the wrap-around check
  logic        found4 = 1'b0;
  logic        rd_en4 = 1'b0;
  logic        clear4 = 1'b0;
  logic        ack4;
  logic        rd_valid4;
  logic [7:0]  rd_seq4;
  logic [3:0]  rd_pos4;
  logic [7:0]  mc4;
  logic        ovf4;
  logic        stk4;
  logic [1:0]  st4;

  int          n_checks = 0;
  int          n_fail = 0;
  int          cur_pos = 0;
  logic [7:0]  m_count = 8'd0;
  logic [23:0] exp_q[$];

  pattern_event_logger u_dut (
    .clk           (clk),
    .reset_sync    (rst),
    .found_pattern (found),
    .ack           (ack),
    .rd_en         (rd_en),
    .rd_valid      (rd_valid),
    .rd_seq        (rd_seq),
    .rd_pos        (rd_pos),
    .match_count   (match_count),
    .overflow      (overflow),
    .stuck_err     (stuck_err),
    .clear_err     (clear_err),
    .state_dbg     (state_dbg)
  );

  pattern_event_logger #(.POS_W(4)) u_dut4 (
    .clk           (clk),
    .reset_sync    (rst),
    .found_pattern (found4),
    .ack           (ack4),
    .rd_en         (rd_en4),
    .rd_valid      (rd_valid4),
    .rd_seq        (rd_seq4),
    .rd_pos        (rd_pos4),
    .match_count   (mc4),
    .overflow      (ovf4),
    .stuck_err     (stk4),
    .clear_err     (clear4),
    .state_dbg     (st4)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks: every step lands 1 time unit after a rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    cur_pos++;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    found = 1'b0;
    found4 = 1'b0;
    rd_en = 1'b0;
    clear_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cur_pos = 0;
    m_count = 8'd0;
    exp_q.delete();
  endtask

  // Raise found at position p for one sampling edge; optionally pop the head
  // in the same cycle. Returns in the ack cycle.
  task automatic do_match(input int p, input bit with_pop);
    logic [23:0] rec;
    while (cur_pos < p) step();
    rec = {m_count, cur_pos[15:0]};
    if (with_pop) begin
      void'(exp_q.pop_front());
      rd_en = 1'b1;
    end
    if (exp_q.size() < 8) exp_q.push_back(rec);
    m_count++;
    found = 1'b1;
    step();
    found = 1'b0;
    rd_en = 1'b0;
    n_checks++;
    if (ack !== 1'b1) begin
      n_fail++;
      $display("FAIL ack_after_match: pos %0d got %b expected 1", p, ack);
    end
  endtask

  task automatic pop_one();
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    void'(exp_q.pop_front());
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    n_checks++;
    if ({ack, rd_valid, rd_seq, rd_pos, match_count, overflow, stuck_err, state_dbg} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: ack=%b v=%b seq=%0h pos=%0h mc=%0h ovf=%b stk=%b st=%0d expected all zero",
               ack, rd_valid, rd_seq, rd_pos, match_count, overflow, stuck_err, state_dbg);
    end
    apply_reset();
  endtask

  task automatic test_single_match();
    apply_reset();
    do_match(12, 1'b0);
    n_checks++;
    if ({rd_valid, rd_seq, rd_pos} !== {1'b1, 8'd0, 16'd12}) begin
      n_fail++;
      $display("FAIL single_record: v=%b seq=%0d pos=%0d expected v=1 seq=0 pos=12", rd_valid, rd_seq, rd_pos);
    end
    n_checks++;
    if ({match_count, overflow, stuck_err} !== {8'd1, 2'b00}) begin
      n_fail++;
      $display("FAIL single_count: mc=%0d ovf=%b stk=%b expected 1 0 0", match_count, overflow, stuck_err);
    end
    step();
    n_checks++;
    if ({ack, state_dbg} !== {1'b0, 2'd2}) begin
      n_fail++;
      $display("FAIL ack_one_cycle: ack=%b st=%0d expected ack=0 st=2", ack, state_dbg);
    end
    step();
    n_checks++;
    if (state_dbg !== 2'd0) begin
      n_fail++;
      $display("FAIL back_to_idle: st=%0d expected 0", state_dbg);
    end
    pop_one();
    n_checks++;
    if (rd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_pop_empty: v=%b expected 0", rd_valid);
    end
  endtask

  task automatic test_three_matches();
    apply_reset();
    do_match(12, 1'b0);
    do_match(17, 1'b0);
    do_match(22, 1'b0);
    step();
    n_checks++;
    if (match_count !== 8'd3) begin
      n_fail++;
      $display("FAIL three_count: got %0d expected 3", match_count);
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({rd_valid, rd_seq, rd_pos} !== {1'b1, 8'(i), 16'(12 + 5 * i)}) begin
        n_fail++;
        $display("FAIL three_head%0d: v=%b seq=%0d pos=%0d expected v=1 seq=%0d pos=%0d",
                 i, rd_valid, rd_seq, rd_pos, i, 12 + 5 * i);
      end
      pop_one();
    end
    n_checks++;
    if (rd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL three_empty: v=%b expected 0", rd_valid);
    end
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    n_checks++;
    if ({rd_valid, rd_seq, rd_pos, match_count, overflow} !== {1'b0, 8'd0, 16'd0, 8'd3, 1'b0}) begin
      n_fail++;
      $display("FAIL underflow_ignored: v=%b seq=%0d pos=%0d mc=%0d ovf=%b expected 0 0 0 3 0",
               rd_valid, rd_seq, rd_pos, match_count, overflow);
    end
  endtask

  task automatic test_overflow();
    apply_reset();
    for (int i = 0; i < 9; i++) do_match(2 + 3 * i, 1'b0);
    n_checks++;
    if ({overflow, match_count, rd_valid} !== {1'b1, 8'd9, 1'b1}) begin
      n_fail++;
      $display("FAIL overflow_set: ovf=%b mc=%0d v=%b expected 1 9 1", overflow, match_count, rd_valid);
    end
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    n_checks++;
    if (overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL overflow_clear: got %b expected 0", overflow);
    end
    // Push and pop together while full: nothing is lost
    do_match(cur_pos + 1, 1'b1);
    n_checks++;
    if ({overflow, match_count} !== {1'b0, 8'd10}) begin
      n_fail++;
      $display("FAIL push_pop_full: ovf=%b mc=%0d expected 0 10", overflow, match_count);
    end
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if ({rd_valid, rd_seq, rd_pos} !== {1'b1, exp_q[0]}) begin
        n_fail++;
        $display("FAIL drain%0d: v=%b seq=%0d pos=%0d expected seq=%0d pos=%0d",
                 i, rd_valid, rd_seq, rd_pos, exp_q[0][23:16], exp_q[0][15:0]);
      end
      pop_one();
    end
    n_checks++;
    if (rd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_empty: v=%b expected 0", rd_valid);
    end
  endtask

  task automatic test_stuck();
    apply_reset();
    while (cur_pos < 5) step();
    found = 1'b1;
    exp_q.push_back({8'd0, 16'd5});
    step();
    n_checks++;
    if (ack !== 1'b1) begin
      n_fail++;
      $display("FAIL stuck_first_ack: got %b expected 1", ack);
    end
    while (cur_pos < 10) step();
    n_checks++;
    if ({stuck_err, state_dbg} !== {1'b0, 2'd2}) begin
      n_fail++;
      $display("FAIL stuck_not_yet: stk=%b st=%0d expected 0 2", stuck_err, state_dbg);
    end
    step();
    n_checks++;
    if ({stuck_err, state_dbg} !== {1'b1, 2'd0}) begin
      n_fail++;
      $display("FAIL stuck_set: stk=%b st=%0d expected 1 0", stuck_err, state_dbg);
    end
    exp_q.push_back({8'd1, 16'd11});
    step();
    n_checks++;
    if ({ack, match_count} !== {1'b1, 8'd2}) begin
      n_fail++;
      $display("FAIL stuck_rematch: ack=%b mc=%0d expected 1 2", ack, match_count);
    end
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    step();
    n_checks++;
    if (stuck_err !== 1'b0) begin
      n_fail++;
      $display("FAIL stuck_clear: got %b expected 0", stuck_err);
    end
    while (cur_pos < 16) step();
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    found = 1'b0;
    n_checks++;
    if ({stuck_err, match_count} !== {1'b1, 8'd2}) begin
      n_fail++;
      $display("FAIL stuck_set_beats_clear: stk=%b mc=%0d expected 1 2", stuck_err, match_count);
    end
    step();
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if ({rd_valid, rd_seq, rd_pos} !== {1'b1, exp_q[0]}) begin
        n_fail++;
        $display("FAIL stuck_rec%0d: v=%b seq=%0d pos=%0d expected seq=%0d pos=%0d",
                 i, rd_valid, rd_seq, rd_pos, exp_q[0][23:16], exp_q[0][15:0]);
      end
      pop_one();
    end
    n_checks++;
    if ({rd_valid, match_count} !== {1'b0, 8'd2}) begin
      n_fail++;
      $display("FAIL stuck_drain: v=%b mc=%0d expected 0 2", rd_valid, match_count);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    do_match(2, 1'b0);
    do_match(5, 1'b0);
    do_match(8, 1'b0);
    do_match(11, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({ack, rd_valid, match_count, state_dbg} !== {1'b0, 1'b0, 8'd0, 2'd0}) begin
      n_fail++;
      $display("FAIL async_reset: ack=%b v=%b mc=%0d st=%0d expected all zero",
               ack, rd_valid, match_count, state_dbg);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cur_pos = 0;
    m_count = 8'd0;
    exp_q.delete();
    do_match(3, 1'b0);
    n_checks++;
    if ({rd_valid, rd_seq, rd_pos, match_count} !== {1'b1, 8'd0, 16'd3, 8'd1}) begin
      n_fail++;
      $display("FAIL pos_restart: v=%b seq=%0d pos=%0d mc=%0d expected 1 0 3 1",
               rd_valid, rd_seq, rd_pos, match_count);
    end
  endtask

  task automatic test_pos_wrap();
    apply_reset();
    while (cur_pos < 17) step();
    found4 = 1'b1;
    step();
    found4 = 1'b0;
    n_checks++;
    if ({ack4, rd_valid4, rd_seq4, rd_pos4} !== {1'b1, 1'b1, 8'd0, 4'd1}) begin
      n_fail++;
      $display("FAIL pos_wrap: ack=%b v=%b seq=%0d pos=%0d expected 1 1 0 1",
               ack4, rd_valid4, rd_seq4, rd_pos4);
    end
  endtask

  // Sequencer and final report
  initial begin
    test_reset();
    test_single_match();
    test_three_matches();
    test_overflow();
    test_stuck();
    test_reset_mid();
    test_pos_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
